// File: rtl/nist_test_sequencer.sv
// Campaign sequencer for the NIST SP 800-22 engines. It frames the random stream into
// fixed-length blocks, resets the engines between blocks and accumulates per-test fail counts.
module nist_test_sequencer #(
    parameter int unsigned BLOCK_LEN = 1024,
    parameter int unsigned NUM_TESTS = 4,
    parameter int unsigned RUNS_W    = 8,
    parameter int unsigned SETTLE    = 4,
    localparam int unsigned SEL_W    = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RUNS_W-1:0]    num_runs,
    input  logic                 rnd_in,
    input  logic [NUM_TESTS-1:0] err_in,
    input  logic [SEL_W-1:0]     sel,
    output logic                 eng_rstn,
    output logic                 eng_bit,
    output logic                 eng_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 fail_any,
    output logic [RUNS_W-1:0]    run_cnt,
    output logic [RUNS_W-1:0]    fail_cnt
);

    localparam int unsigned CNT_MAX = (BLOCK_LEN > SETTLE) ? BLOCK_LEN : SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_FEED,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUNS_W-1:0] num_runs_q, num_runs_d;
    logic [RUNS_W-1:0] run_cnt_q, run_cnt_d;
    logic [RUNS_W-1:0] fail_q [NUM_TESTS];
    logic [RUNS_W-1:0] fail_d [NUM_TESTS];
    logic              fail_any_q, fail_any_d;
    logic              eng_rstn_q, eng_bit_q, eng_valid_q, busy_q, done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        num_runs_d = num_runs_q;
        run_cnt_d  = run_cnt_q;
        fail_d     = fail_q;
        fail_any_d = fail_any_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SETTLE;
                    num_runs_d = num_runs;
                    run_cnt_d  = '0;
                    fail_d     = '{default: '0};
                    fail_any_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // abort wins over sampling: this block's flags are discarded
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
                        if (err_in[i] && (fail_q[i] != '1)) begin
                            fail_d[i] = fail_q[i] + 1'b1;
                        end
                    end
                    if (|err_in) begin
                        fail_any_d = 1'b1;
                    end
                    if (!((num_runs_q != '0) && (run_cnt_q == '1))) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                    if ((num_runs_q != '0) && (run_cnt_d == num_runs_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state entry restarts the shared settle/bit counter
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            num_runs_q  <= '0;
            run_cnt_q   <= '0;
            fail_q      <= '{default: '0};
            fail_any_q  <= 1'b0;
            eng_rstn_q  <= 1'b0;
            eng_bit_q   <= 1'b0;
            eng_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_runs_q  <= num_runs_d;
            run_cnt_q   <= run_cnt_d;
            fail_q      <= fail_d;
            fail_any_q  <= fail_any_d;
            // Outputs registered from the next state so they align with the state they describe
            eng_rstn_q  <= (state_d == S_FEED) || (state_d == S_SAMPLE);
            eng_valid_q <= (state_d == S_FEED);
            eng_bit_q   <= (state_d == S_FEED) ? rnd_in : 1'b0;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    always_comb begin
        fail_cnt = '0;
        for (int unsigned i = 0; i < NUM_TESTS; i++) begin
            if (sel == SEL_W'(i)) begin
                fail_cnt = fail_q[i];
            end
        end
    end

    assign eng_rstn  = eng_rstn_q;
    assign eng_bit   = eng_bit_q;
    assign eng_valid = eng_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail_any  = fail_any_q;
    assign run_cnt   = run_cnt_q;

endmodule

// File: tb/tb_nist_test_sequencer.sv
// Directed bench for nist_test_sequencer: campaign framing, fail counting, saturation/wrap,
// abort handling and asynchronous reset, with a queue scoreboard on the engine bit stream.
module tb_nist_test_sequencer;

    localparam int unsigned BLOCK_LEN = 16;
    localparam int unsigned NUM_TESTS = 4;
    localparam int unsigned RUNS_W    = 4;
    localparam int unsigned SETTLE    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [RUNS_W-1:0] num_runs;
    logic              rnd_in;
    logic [3:0]        err_in;
    logic [1:0]        sel;
    logic              eng_rstn, eng_bit, eng_valid, busy, done, fail_any;
    logic [RUNS_W-1:0] run_cnt, fail_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int valid_run = 0;
    int runs_seen = 0;
    bit len_chk   = 1'b0;
    logic bit_q[$];

    nist_test_sequencer #(
        .BLOCK_LEN(BLOCK_LEN),
        .NUM_TESTS(NUM_TESTS),
        .RUNS_W(RUNS_W),
        .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .num_runs(num_runs),
        .rnd_in(rnd_in),
        .err_in(err_in),
        .sel(sel),
        .eng_rstn(eng_rstn),
        .eng_bit(eng_bit),
        .eng_valid(eng_valid),
        .busy(busy),
        .done(done),
        .fail_any(fail_any),
        .run_cnt(run_cnt),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: settle after the edge, score the engine bit, then drive a fresh random bit.
    task automatic step();
        logic exp_b;
        @(posedge clk);
        #1;
        if (bit_q.size() > 0) begin
            exp_b = bit_q.pop_front();
            if (eng_valid) chk("eng_bit", {31'd0, eng_bit}, {31'd0, exp_b});
        end
        if (eng_valid) begin
            valid_run++;
        end else if (valid_run != 0) begin
            runs_seen++;
            if (len_chk) chk("valid_len", valid_run, BLOCK_LEN);
            valid_run = 0;
        end
        rnd_in = 1'($urandom_range(0, 1));
        bit_q.push_back(rnd_in);
    endtask

    function automatic bit in_sample();
        return eng_rstn && !eng_valid;
    endfunction

    initial begin
        int first_valid;
        int done_at;
        int done_cnt;
        int samples;
        int blk;
        bit stop;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_runs = '0;
        rnd_in = 1'b0; err_in = '0; sel = '0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_eng_rstn", eng_rstn, 0);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_run_cnt", run_cnt, 0);
        chk("rst_fail_any", fail_any, 0);
        rst_n = 1'b1;
        step();

        // Three-block campaign with clean engines
        num_runs = 4'd3; start = 1'b1; len_chk = 1'b1; runs_seen = 0;
        step();
        start = 1'b0;
        chk("t2_busy_start", busy, 1);
        first_valid = -1; done_at = -1; done_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (k == 1) chk("t2_rstn_settle", eng_rstn, 0);
            if (k == 2) chk("t2_rstn_feed", eng_rstn, 1);
            if (k == 20) chk("t2_settle_gap", eng_valid, 0);
            if (k == 21) chk("t2_period", eng_valid, 1);
            if (eng_valid && first_valid < 0) first_valid = k;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (!busy) break;
        end
        len_chk = 1'b0;
        chk("t2_timeout", busy, 0);
        chk("t2_first_valid", first_valid, SETTLE);
        chk("t2_done_at", done_at, 3 * (SETTLE + BLOCK_LEN + 1));
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_blocks", runs_seen, 3);
        chk("t2_run_cnt", run_cnt, 3);
        chk("t2_fail_any", fail_any, 0);

        // Two blocks, flags 0101 only in the SAMPLE cycles
        num_runs = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            err_in = in_sample() ? 4'b0101 : 4'b0000;
            if (!busy) break;
        end
        err_in = '0;
        chk("t3_timeout", busy, 0);
        sel = 2'd0; #1 chk("t3_fail0", fail_cnt, 2);
        sel = 2'd1; #1 chk("t3_fail1", fail_cnt, 0);
        sel = 2'd2; #1 chk("t3_fail2", fail_cnt, 2);
        chk("t3_fail_any", fail_any, 1);
        chk("t3_run_cnt", run_cnt, 2);

        // Continuous mode: 20 blocks with err_in[3] always set
        num_runs = 4'd0; err_in = 4'b1000; sel = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_fail3_cleared", fail_cnt, 0);
        samples = 0; done_cnt = 0;
        for (int k = 0; k < 20 * 19 + 50 && samples < 20; k++) begin
            step();
            if (done) done_cnt++;
            if (in_sample()) samples++;
        end
        step();
        chk("t4_samples", samples, 20);
        chk("t4_fail3_sat", fail_cnt, 15);
        chk("t4_run_wrap", run_cnt, 4);
        chk("t4_busy", busy, 1);
        chk("t4_no_done", done_cnt, 0);
        err_in = '0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_abort_idle", busy, 0);

        // Abort at bit 7 of block 2; new start must clear counters
        num_runs = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_run_cleared", run_cnt, 0);
        chk("t5_fail_any_cleared", fail_any, 0);
        chk("t5_fail3_cleared", fail_cnt, 0);
        blk = 0; stop = 1'b0;
        for (int k = 0; k < 200 && !stop; k++) begin
            step();
            if (eng_valid && valid_run == 1) blk++;
            if (blk == 2 && eng_valid && valid_run == 8) stop = 1'b1;
        end
        chk("t5_reached_bit7", stop, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_valid", eng_valid, 0);
        chk("t5_rstn", eng_rstn, 0);
        chk("t5_done", done, 0);
        chk("t5_run_kept", run_cnt, 1);
        step();
        chk("t5_no_done_late", done, 0);

        // Start during FEED is ignored; abort in SAMPLE discards the block
        num_runs = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        blk = 0; stop = 1'b0;
        for (int k = 0; k < 200 && !stop; k++) begin
            step();
            if (in_sample()) begin
                blk++;
                if (blk == 1) begin
                    err_in = 4'b0101;
                end else begin
                    err_in = 4'b1111;
                    abort = 1'b1;
                    stop = 1'b1;
                end
            end else begin
                err_in = '0;
            end
            if (blk == 1 && eng_valid && valid_run == 4) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk("t6_start_ign_valid", eng_valid, 1);
                chk("t6_start_ign_run", run_cnt, 1);
            end
        end
        chk("t6_reached_sample", blk, 2);
        step();
        abort = 1'b0; err_in = '0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_run_cnt", run_cnt, 1);
        sel = 2'd0; #1 chk("t6_fail0", fail_cnt, 1);
        sel = 2'd1; #1 chk("t6_fail1", fail_cnt, 0);
        sel = 2'd2; #1 chk("t6_fail2", fail_cnt, 1);
        sel = 2'd3; #1 chk("t6_fail3", fail_cnt, 0);

        // Asynchronous reset in the middle of block 2
        num_runs = 4'd0; err_in = 4'b0001; sel = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 200 && !(run_cnt == 4'd1 && eng_valid && valid_run == 5); k++) begin
            step();
        end
        chk("t1_pre_run", run_cnt, 1);
        chk("t1_pre_fail_any", fail_any, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_valid", eng_valid, 0);
        chk("t1_rstn", eng_rstn, 0);
        chk("t1_run_cnt", run_cnt, 0);
        chk("t1_fail_any", fail_any, 0);
        chk("t1_fail0", fail_cnt, 0);
        err_in = '0;
        step();
        rst_n = 1'b1;
        step();
        chk("t1_idle_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nist_test_sequencer.md
Name: nist_test_sequencer

Overview:
- Campaign controller that drives the NIST SP 800-22 test engines from the ALFSR random bit stream.
- Frames the stream into fixed-length blocks and holds the engines in reset between blocks.
- Samples each engine's error flag at the end of every block and accumulates per-test saturating fail counts for readout.
- Sits between the bit source (synchronised ALFSR digital output or the external RND pin) and the test engines.

Parameters:
- BLOCK_LEN, 1024, number of bits fed per block; must be ≥16.
- NUM_TESTS, 4, number of engine error flags.
- RUNS_W, 8, width of the run counter and the fail counters.
- SETTLE, 4, number of cycles engines are held in reset before each block; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin campaign; sampled in IDLE only.
- abort  in  1  stop campaign; sampled in any non-IDLE state.
- num_runs  in  RUNS_W  number of blocks to run; latched at start; 0 means run continuously.
- rnd_in  in  1  random bit, already synchronous to clk.
- err_in  in  NUM_TESTS  engine error flags, valid in the SAMPLE cycle.
- sel  in  clog2(NUM_TESTS)  selects which fail counter appears on fail_cnt.
- eng_rstn  out  1  active-low reset to the test engines.
- eng_bit  out  1  bit to the engines.
- eng_valid  out  1  eng_bit is valid this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a campaign completes.
- fail_any  out  1  sticky: any error seen since the last start.
- run_cnt  out  RUNS_W  number of completed blocks.
- fail_cnt  out  RUNS_W  fail counter selected by sel (combinational mux).

Behaviour:
- Reset (async on rst_n low):
  - State = IDLE.
  - All counters = 0.
  - eng_rstn=0, eng_valid=0, eng_bit=0, done=0, fail_any=0.
- States: IDLE, SETTLE, FEED, SAMPLE, DONE. All outputs except fail_cnt are registered.
- IDLE:
  - eng_rstn=0.
  - start=1 → next state SETTLE. Same edge: latch num_runs, clear run_cnt, all fail counters and fail_any.
  - start is ignored in every other state.
- SETTLE:
  - eng_rstn=0 for exactly SETTLE cycles, then FEED.
- FEED:
  - eng_rstn=1.
  - Each cycle, eng_bit <= rnd_in and eng_valid <= 1. Output appears one cycle after rnd_in is sampled.
  - A bit counter runs 0..BLOCK_LEN-1. eng_valid is high for exactly BLOCK_LEN consecutive cycles per block.
  - After the last bit → SAMPLE.
- SAMPLE (1 cycle):
  - eng_rstn=1, eng_valid=0.
  - For each i with err_in[i]=1: fail counter i increments, saturating at 2^RUNS_W-1, and fail_any is set.
  - run_cnt increments; it saturates when num_runs≠0 and wraps when num_runs=0.
  - If latched num_runs≠0 and the new run_cnt==num_runs → DONE; otherwise → SETTLE.
- DONE: done=1 for 1 cycle, eng_rstn=0, → IDLE.
- Per-block period = SETTLE + BLOCK_LEN + 1 cycles.
- abort:
  - In SETTLE, FEED or SAMPLE → IDLE on the next edge. eng_valid drops and eng_rstn=0.
  - No done pulse. Counters are retained for readout.
  - An abort in the SAMPLE cycle takes priority; that block's flags are not counted.
  - An abort in DONE has no effect (DONE → IDLE anyway).
- Changes to num_runs after start have no effect. Changes to sel take effect immediately on fail_cnt.
- Bit-counter wrap: the counter is reset on entering FEED; no partial block is ever sampled.

Test Plan (BLOCK_LEN=16, SETTLE=2, RUNS_W=4, NUM_TESTS=4):
1. Reset mid-FEED (rst_n low for 1 cycle):
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - busy=0, run_cnt=0, fail_any=0.
2. start with num_runs=3, err_in held 0:
   - eng_rstn low 2 cycles, then eng_valid high 16 cycles. Pattern repeats 3 times, 19-cycle period.
   - done pulses once, 57 cycles after start + 1.
   - run_cnt=3, fail_any=0.
   - eng_bit equals rnd_in delayed by one cycle.
3. num_runs=2, err_in=4'b0101 in the SAMPLE cycles only:
   - fail_cnt: sel=0 → 2, sel=1 → 0, sel=2 → 2.
   - fail_any=1.
4. num_runs=0, err_in[3]=1 every block, run 20 blocks:
   - fail_cnt(sel=3) saturates at 15.
   - run_cnt wraps to 4.
   - No done pulse; busy stays 1.
5. abort asserted at bit 7 of block 2:
   - Next cycle: busy=0, eng_valid=0, eng_rstn=0, no done pulse.
   - run_cnt=1 retained.
   - A new start clears counters.
6. start pulsed during FEED, and abort in the SAMPLE cycle with err_in=4'b1111:
   - The start is ignored.
   - The abort returns the block to IDLE; fail counters are unchanged and run_cnt does not increment.
